// File: rtl/circuit_with_udp_02467.sv
// Registered Boolean decode leaf: e = Sum(0,2,4,6,7)(a,b,c), f = e & d,
// g = majority-of-three over (a,b,c,d), delivered through a LATENCY-deep pipe.
module circuit_with_udp_02467 #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic out_valid
);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("circuit_with_udp_02467: LATENCY must be in 1..4");
    end

    typedef struct packed {
        logic e;
        logic f;
        logic g;
        logic valid;
    } stage_t;

    logic   e_c;
    logic   f_c;
    logic   g_c;
    stage_t stage_d;
    stage_t stage_q [LATENCY];

    always_comb begin
        e_c     = ~c | (a & b);
        f_c     = e_c & d;
        g_c     = (a & b & c) | (a & b & d) | (a & c & d) | (b & c & d);
        stage_d = '{e: e_c, f: f_c, g: g_c, valid: in_valid};
    end

    // NOTE: every stage, data included, is cleared so a reset drops in-flight
    // samples and the outputs read all-zero until real data arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make each stage take its
            // predecessor's old value, so the chain shifts by exactly one.
            stage_q[0] <= stage_d;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign e         = stage_q[LATENCY-1].e;
    assign f         = stage_q[LATENCY-1].f;
    assign g         = stage_q[LATENCY-1].g;
    assign out_valid = stage_q[LATENCY-1].valid;

endmodule

// File: tb/tb_circuit_with_udp_02467.sv
// Directed self-checking bench for circuit_with_udp_02467 at LATENCY=1 and 3.
module tb_circuit_with_udp_02467;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic a, b, c, d;
    logic e1, f1, g1, v1;
    logic e3, f3, g3, v3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    circuit_with_udp_02467 #(.LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d),
        .e(e1), .f(f1), .g(g1), .out_valid(v1)
    );

    circuit_with_udp_02467 #(.LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d),
        .e(e3), .f(f3), .g(g3), .out_valid(v3)
    );

    // Observed/expected values are packed as {e, f, g, out_valid}.
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: efgv observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one sample right after an edge, then move to 1 time unit past the next edge.
    task automatic step(input logic [3:0] abcd, input logic vld, input logic r);
        {a, b, c, d} = abcd;
        in_valid     = vld;
        rst          = r;
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  e_mask;
    logic [15:0] g_mask;
    logic [3:0]  idx;
    logic        exp_e, exp_g;

    initial begin
        e_mask = 8'hD5;     // minterms 0,2,4,6,7 of (a,b,c)
        g_mask = 16'hE880;  // minterms 7,11,13,14,15 of (a,b,c,d)

        // Reset held with all-ones valid input.
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b1, 1'b1);
            check("rst_hold_l1", {e1, f1, g1, v1}, 4'b0000);
            check("rst_hold_l3", {e3, f3, g3, v3}, 4'b0000);
        end
        step(4'b1111, 1'b1, 1'b0);
        check("rst_release_l1", {e1, f1, g1, v1}, 4'b1111);
        check("rst_release_l3", {e3, f3, g3, v3}, 4'b0000);

        // Exhaustive sweep, expectations from minterm masks.
        for (int i = 0; i < 16; i++) begin
            idx   = 4'(i);
            exp_e = e_mask[idx[3:1]];
            exp_g = g_mask[idx];
            step(idx, 1'b1, 1'b0);
            check($sformatf("sweep_%b", idx), {e1, f1, g1, v1},
                  {exp_e, exp_e & idx[0], exp_g, 1'b1});
        end

        // Directed sequence.
        step(4'b1100, 1'b1, 1'b0); check("dir_1100", {e1, f1, g1, v1}, 4'b1001);
        step(4'b1110, 1'b1, 1'b0); check("dir_1110", {e1, f1, g1, v1}, 4'b1011);
        step(4'b1111, 1'b1, 1'b0); check("dir_1111", {e1, f1, g1, v1}, 4'b1111);
        step(4'b1001, 1'b1, 1'b0); check("dir_1001", {e1, f1, g1, v1}, 4'b1101);
        step(4'b1010, 1'b1, 1'b0); check("dir_1010", {e1, f1, g1, v1}, 4'b0001);
        step(4'b0100, 1'b1, 1'b0); check("dir_0100", {e1, f1, g1, v1}, 4'b1001);
        step(4'b0111, 1'b1, 1'b0); check("dir_0111", {e1, f1, g1, v1}, 4'b0011);
        step(4'b0001, 1'b1, 1'b0); check("dir_0001", {e1, f1, g1, v1}, 4'b1101);

        // Valid tracking: data still flows when in_valid is low.
        step(4'b1100, 1'b1, 1'b0); check("vld_1", {e1, f1, g1, v1}, 4'b1001);
        step(4'b0111, 1'b0, 1'b0); check("vld_0", {e1, f1, g1, v1}, 4'b0010);
        step(4'b0001, 1'b1, 1'b0); check("vld_1b", {e1, f1, g1, v1}, 4'b1101);

        // Mid-stream reset pulse.
        step(4'b1111, 1'b1, 1'b0); check("mid_pre_a", {e1, f1, g1, v1}, 4'b1111);
        step(4'b0111, 1'b1, 1'b0); check("mid_pre_b", {e1, f1, g1, v1}, 4'b0011);
        step(4'b1111, 1'b1, 1'b1); check("mid_rst_l1", {e1, f1, g1, v1}, 4'b0000);
        check("mid_rst_l3", {e3, f3, g3, v3}, 4'b0000);
        step(4'b0001, 1'b1, 1'b0); check("mid_post_a", {e1, f1, g1, v1}, 4'b1101);
        step(4'b1110, 1'b1, 1'b0); check("mid_post_b", {e1, f1, g1, v1}, 4'b1011);

        // LATENCY=3: fill with 1010 (e=0), then 0000 (e=1).
        for (int i = 0; i < 3; i++) step(4'b1010, 1'b1, 1'b0);
        check("l3_fill_1010", {e3, f3, g3, v3}, 4'b0001);
        step(4'b0000, 1'b1, 1'b0); check("l3_0000_c1", {e3, f3, g3, v3}, 4'b0001);
        step(4'b0000, 1'b0, 1'b0); check("l3_0000_c2", {e3, f3, g3, v3}, 4'b0001);
        step(4'b0000, 1'b0, 1'b0); check("l3_0000_c3", {e3, f3, g3, v3}, 4'b1001);
        step(4'b1010, 1'b1, 1'b0); check("l3_inv_c4", {e3, f3, g3, v3}, 4'b1000);
        step(4'b1010, 1'b1, 1'b0); check("l3_inv_c5", {e3, f3, g3, v3}, 4'b1000);
        step(4'b1010, 1'b1, 1'b0); check("l3_1010_c6", {e3, f3, g3, v3}, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
